pixel_unpacker: RTL

//  Sink end of the packed-RGB video AXI4-Stream written by the pixel generator's packer.

---
 rtl/pixel_unpacker.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/pixel_unpacker.sv
// Sink for the packed-RGB stream: 3 x 32-bit words carry 4 x 24-bit pixels.
// Emits one tagged pixel per beat and keeps frame / framing-error status.
module pixel_unpacker #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] in_stream_tdata,
  input  logic [3:0]  in_stream_tkeep,
  input  logic        in_stream_tlast,
  input  logic        in_stream_tuser,
  input  logic        in_stream_tvalid,
  output logic        in_stream_tready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] frame_count,
  output logic        sof_err,
  output logic        eol_err,
  input  logic        err_clr
);

  typedef enum logic {WAIT_SOF, ACTIVE} state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [15:0] XMAX = 16'(WIDTH - 1);
  localparam logic [15:0] YMAX = 16'(HEIGHT - 1);
  localparam logic [15:0] XPRE = 16'(WIDTH - 2);

  state_t      state_q, state_d;
  logic [1:0]  phase_q, phase_d, eff_phase;
  logic [23:0] hold_q, hold_d;
  logic [15:0] x_q, x_d, y_q, y_d, ld_x, ld_y;
  logic        load_ok, tready, ld, sof_set, eol_set, frame_done;
  rgb_t        ld_pix;
  logic        unused_tkeep;

  assign unused_tkeep     = ^in_stream_tkeep;
  assign load_ok          = !pix_valid || pix_ready;
  assign in_stream_tready = tready;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    x_d        = x_q;
    y_d        = y_q;
    tready     = 1'b0;
    ld         = 1'b0;
    eff_phase  = phase_q;
    ld_x       = x_q;
    ld_y       = y_q;
    ld_pix     = '0;
    sof_set    = 1'b0;
    eol_set    = 1'b0;
    frame_done = 1'b0;

    unique case (state_q)
      WAIT_SOF: begin
        // Only an SOF word needs the output register; others are dropped freely.
        tready = !in_stream_tuser || load_ok;
        if (in_stream_tvalid && tready && in_stream_tuser) begin
          ld        = 1'b1;
          eff_phase = 2'd0;
          ld_x      = '0;
          ld_y      = '0;
        end
      end
      ACTIVE: begin
        tready = (phase_q != 2'd3) && load_ok;
        if (phase_q == 2'd3) begin
          ld = load_ok;
        end else if (in_stream_tvalid && tready) begin
          ld = 1'b1;
          if (in_stream_tuser && !(phase_q == 2'd0 && x_q == '0 && y_q == '0)) begin
            sof_set   = 1'b1;
            eff_phase = 2'd0;
            ld_x      = '0;
            ld_y      = '0;
          end
        end
      end
    endcase

    if (ld) begin
      unique case (eff_phase)
        2'd0: begin
          ld_pix = rgb_t'(in_stream_tdata[23:0]);
          hold_d = {16'h0, in_stream_tdata[31:24]};
        end
        2'd1: begin
          ld_pix = rgb_t'({in_stream_tdata[15:0], hold_q[7:0]});
          hold_d = {8'h0, in_stream_tdata[31:16]};
        end
        2'd2: begin
          ld_pix = rgb_t'({in_stream_tdata[7:0], hold_q[15:0]});
          hold_d = in_stream_tdata[31:8];
        end
        default: ld_pix = rgb_t'(hold_q);
      endcase

      // The phase2 word also carries the following pixel, so it ends the line when x==WIDTH-2.
      if (eff_phase != 2'd3)
        eol_set = in_stream_tlast != (eff_phase == 2'd2 && ld_x == XPRE);

      phase_d = 2'(eff_phase + 2'd1);
      state_d = ACTIVE;
      if (ld_x == XMAX) begin
        x_d = '0;
        if (ld_y == YMAX) begin
          y_d        = '0;
          phase_d    = 2'd0;
          state_d    = WAIT_SOF;
          frame_done = 1'b1;
        end else begin
          y_d = 16'(ld_y + 16'd1);
        end
      end else begin
        x_d = 16'(ld_x + 16'd1);
        y_d = ld_y;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= WAIT_SOF;
      phase_q     <= 2'd0;
      hold_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      pix_valid   <= 1'b0;
      pix_r       <= '0;
      pix_g       <= '0;
      pix_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_sof     <= 1'b0;
      pix_eol     <= 1'b0;
      frame_count <= '0;
      sof_err     <= 1'b0;
      eol_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (ld) begin
        pix_valid <= 1'b1;
        pix_r     <= ld_pix.r;
        pix_g     <= ld_pix.g;
        pix_b     <= ld_pix.b;
        pix_x     <= ld_x;
        pix_y     <= ld_y;
        pix_sof   <= (ld_x == '0) && (ld_y == '0);
        pix_eol   <= ld_x == XMAX;
      end else if (pix_ready) begin
        pix_valid <= 1'b0;
      end
      if (frame_done)
        frame_count <= 16'(frame_count + 16'd1);
      // A new error beats a simultaneous clear.
      sof_err <= sof_set || (sof_err && !err_clr);
      eol_err <= eol_set || (eol_err && !err_clr);
    end
  end

endmodule
